// File: rtl/genius_user_counter.sv
// User-phase index counter for the Genius game: checks each key press against the stored sequence.
// Optional idle-press timeout is compiled in when USER_TIMEOUT_EN is defined.
module genius_user_counter #(
    parameter int SIZE           = 4,
    parameter int KEY_W          = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             R,
    input  logic             E,
    input  logic [SIZE-1:0]  data,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    input  logic [KEY_W-1:0] exp_code,
    output logic [SIZE-1:0]  SEQUSER,
    output logic             end_User,
    output logic             err_User,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        FAIL
    } state_t;

    state_t          state_q, state_nxt;
    logic [SIZE-1:0] seq_q, seq_nxt;
    logic [SIZE-1:0] last_q, last_nxt;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef USER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q, timer_nxt;
    logic          expired;

    assign expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= IDLE;
            seq_q   <= '0;
            last_q  <= '0;
`ifdef USER_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            seq_q   <= seq_nxt;
            last_q  <= last_nxt;
`ifdef USER_TIMEOUT_EN
            timer_q <= timer_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state_q;
        seq_nxt   = seq_q;
        last_nxt  = last_q;
`ifdef USER_TIMEOUT_EN
        // Timer falls back to zero outside WAIT and on every press.
        timer_nxt = '0;
`endif
        case (state_q)
            IDLE: begin
                if (E) begin
                    state_nxt = WAIT;
                    last_nxt  = data;
                    seq_nxt   = '0;
                end
            end
            WAIT: begin
                if (!E) begin
                    state_nxt = IDLE;
                    seq_nxt   = '0;
                end else if (key_valid) begin
                    if (key_code != exp_code) begin
                        state_nxt = FAIL;
                    end else if (seq_q == last_q) begin
                        state_nxt = DONE;
                    end else begin
                        seq_nxt = seq_q + SIZE'(1);
                    end
                end
`ifdef USER_TIMEOUT_EN
                else if (expired) begin
                    state_nxt = FAIL;
                end else begin
                    timer_nxt = timer_q + TW'(1);
                end
`endif
            end
            DONE, FAIL: begin
                if (!E) begin
                    state_nxt = IDLE;
                    seq_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                seq_nxt   = '0;
            end
        endcase
    end

    // Flags are decoded from the state so they can never be high together.
    assign SEQUSER  = seq_q;
    assign end_User = (state_q == DONE);
    assign err_User = (state_q == FAIL);
    assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_genius_user_counter.sv
// Randomized self-checking bench for genius_user_counter; expectations derive from the key list position.
// Build with USER_TIMEOUT_EN defined to exercise the timeout with TIMEOUT_CYCLES=8.
module tb_genius_user_counter;

    localparam int SIZE  = 4;
    localparam int KEY_W = 2;
`ifdef USER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1000;
`endif

    logic             clk = 1'b0;
    logic             R;
    logic             E;
    logic [SIZE-1:0]  data;
    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic [KEY_W-1:0] exp_code;
    logic [SIZE-1:0]  SEQUSER;
    logic             end_User;
    logic             err_User;
    logic             busy;

    logic [KEY_W-1:0] mem [16];
    logic [6:0]       obs;
    logic [6:0]       exp_v;

    int checks = 0;
    int errors = 0;

    genius_user_counter #(
        .SIZE(SIZE),
        .KEY_W(KEY_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .R(R),
        .E(E),
        .data(data),
        .key_valid(key_valid),
        .key_code(key_code),
        .exp_code(exp_code),
        .SEQUSER(SEQUSER),
        .end_User(end_User),
        .err_User(err_User),
        .busy(busy)
    );

    // Sequence memory model: combinational read at the index the DUT presents.
    assign exp_code = mem[SEQUSER];
    assign obs      = {SEQUSER, end_User, err_User, busy};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = KEY_W'($urandom_range(0, 3));
    endtask

    task automatic start_round(input logic [SIZE-1:0] d);
        data = d;
        E    = 1'b1;
        step();
    endtask

    task automatic press(input logic [KEY_W-1:0] c);
        key_code  = c;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        key_code  = KEY_W'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        R = 1'b1; E = 1'b0; key_valid = 1'b0; data = '0; key_code = '0;
        fill_mem();
        step();
        step();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0);
        end
        R = 1'b0;
        start_round(4'd3);
        checks++;
        if (obs !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_enter_wait got=%b exp=%b", obs, {4'd0, 3'b001});
        end
        E = 1'b0;
        step();
    endtask

    task automatic test_full_round();
        for (int r = 0; r < 6; r++) begin
            int d;
            d = (r == 0) ? 3 : $urandom_range(0, 15);
            fill_mem();
            if (r == 0) begin
                mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
            end
            start_round(SIZE'(d));
            data = SIZE'($urandom_range(0, 15));
            for (int i = 0; i <= d; i++) begin
                int gap;
                gap = (r == 0) ? 2 : $urandom_range(0, 2);
                repeat (gap) step();
                checks++;
                if (obs !== {4'(i), 3'b001}) begin
                    errors++;
                    $display("FAIL round_idle r=%0d i=%0d got=%b exp=%b", r, i, obs, {4'(i), 3'b001});
                end
                press(mem[i]);
                exp_v = (i == d) ? {4'(d), 3'b100} : {4'(i + 1), 3'b001};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL round_press r=%0d i=%0d got=%b exp=%b", r, i, obs, exp_v);
                end
            end
            press(KEY_W'($urandom_range(0, 3)));
            step();
            checks++;
            if (obs !== {4'(d), 3'b100}) begin
                errors++;
                $display("FAIL round_hold r=%0d got=%b exp=%b", r, obs, {4'(d), 3'b100});
            end
            E = 1'b0;
            step();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL round_exit r=%0d got=%b exp=%b", r, obs, 7'b0);
            end
        end
    endtask

    task automatic test_error();
        for (int r = 0; r < 6; r++) begin
            int d, p;
            logic [KEY_W-1:0] wrong;
            d = (r == 0) ? 3 : $urandom_range(1, 15);
            p = (r == 0) ? 1 : $urandom_range(0, d);
            fill_mem();
            if (r == 0) begin
                mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
            end
            start_round(SIZE'(d));
            for (int i = 0; i < p; i++) press(mem[i]);
            wrong = (r == 0) ? 2'd1 : mem[p] ^ KEY_W'($urandom_range(1, 3));
            press(wrong);
            checks++;
            if (obs !== {4'(p), 3'b010}) begin
                errors++;
                $display("FAIL error_flag r=%0d p=%0d got=%b exp=%b", r, p, obs, {4'(p), 3'b010});
            end
            press(mem[p]);
            press(mem[p]);
            checks++;
            if (obs !== {4'(p), 3'b010}) begin
                errors++;
                $display("FAIL error_hold r=%0d got=%b exp=%b", r, obs, {4'(p), 3'b010});
            end
            E = 1'b0;
            step();
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL error_exit r=%0d got=%b exp=%b", r, obs, 7'b0);
            end
        end
    endtask

    task automatic test_data_zero();
        fill_mem();
        start_round(4'd0);
        press(mem[0]);
        checks++;
        if (obs !== {4'd0, 3'b100}) begin
            errors++;
            $display("FAIL data_zero got=%b exp=%b", obs, {4'd0, 3'b100});
        end
        E = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            int d;
            d = (r == 0) ? 2 : $urandom_range(1, 15);
            fill_mem();
            start_round(SIZE'(d));
            key_valid = 1'b1;
            for (int i = 0; i <= d; i++) begin
                key_code = mem[i];
                step();
                exp_v = (i == d) ? {4'(d), 3'b100} : {4'(i + 1), 3'b001};
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL b2b r=%0d i=%0d got=%b exp=%b", r, i, obs, exp_v);
                end
            end
            key_valid = 1'b0;
            E = 1'b0;
            step();
        end
    endtask

    task automatic test_e_drop();
        fill_mem();
        start_round(4'd5);
        press(mem[0]);
        press(mem[1]);
        E = 1'b0;
        key_code = mem[2];
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL e_drop got=%b exp=%b", obs, 7'b0);
        end
        step();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL e_drop_idle got=%b exp=%b", obs, 7'b0);
        end
    endtask

    task automatic test_reset_in_done();
        int d;
        d = $urandom_range(0, 15);
        fill_mem();
        start_round(SIZE'(d));
        for (int i = 0; i <= d; i++) press(mem[i]);
        checks++;
        if (obs !== {4'(d), 3'b100}) begin
            errors++;
            $display("FAIL rst_done_pre got=%b exp=%b", obs, {4'(d), 3'b100});
        end
        R = 1'b1;
        step();
        R = 1'b0;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL rst_done_clear got=%b exp=%b", obs, 7'b0);
        end
        step();
        checks++;
        if (obs !== {4'd0, 3'b001}) begin
            errors++;
            $display("FAIL rst_done_reenter got=%b exp=%b", obs, {4'd0, 3'b001});
        end
        E = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        fill_mem();
`ifdef USER_TIMEOUT_EN
        start_round(4'd3);
        repeat (TO - 1) step();
        checks++;
        if (obs !== {4'd0, 3'b001}) begin
            errors++;
            $display("FAIL timeout_early got=%b exp=%b", obs, {4'd0, 3'b001});
        end
        step();
        checks++;
        if (obs !== {4'd0, 3'b010}) begin
            errors++;
            $display("FAIL timeout_expire got=%b exp=%b", obs, {4'd0, 3'b010});
        end
        E = 1'b0;
        step();
        start_round(4'd3);
        repeat (5) step();
        press(mem[0]);
        repeat (TO - 1) step();
        checks++;
        if (obs !== {4'd1, 3'b001}) begin
            errors++;
            $display("FAIL timeout_restart got=%b exp=%b", obs, {4'd1, 3'b001});
        end
        step();
        checks++;
        if (obs !== {4'd1, 3'b010}) begin
            errors++;
            $display("FAIL timeout_restart_expire got=%b exp=%b", obs, {4'd1, 3'b010});
        end
`else
        start_round(4'd3);
        repeat (TO + 20) step();
        checks++;
        if (obs !== {4'd0, 3'b001}) begin
            errors++;
            $display("FAIL no_timeout got=%b exp=%b", obs, {4'd0, 3'b001});
        end
`endif
        E = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_error();
        test_data_zero();
        test_back_to_back();
        test_e_drop();
        test_reset_in_done();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/genius_user_counter.md
Name: genius_user_counter

Overview:
- User-side companion of the FPGA sequence playback counter in the Genius game datapath.
- While the player repeats the sequence, it counts accepted key presses and presents the current index to the sequence memory.
- Each pressed key is compared against the stored element; the block flags round complete or player error to the top-level game FSM.

Parameters:
- SIZE, 4, width of sequence index and of round length `data`.
- KEY_W, 2, width of a key code (4 buttons).
- TIMEOUT_CYCLES, 1000, idle-press limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- R  in  1  reset; synchronous, active-high; clears all state.
- E  in  1  enable of user phase, level; high for the whole player turn.
- data  in  SIZE  index of the last element of this round (round length minus 1).
- key_valid  in  1  one-cycle strobe of a debounced button press.
- key_code  in  KEY_W  code of the pressed button; valid with key_valid.
- exp_code  in  KEY_W  stored element at index SEQUSER, from sequence memory (combinational read).
- SEQUSER  out  SIZE  current index being checked.
- end_User  out  1  round repeated correctly; held.
- err_User  out  1  wrong key (or timeout); held.
- busy  out  1  high in WAIT state.

Behaviour:
- Only synchronous logic; single always on posedge clk; R has priority over every other input.
- Reset values: SEQUSER=0, end_User=0, err_User=0, busy=0, state=IDLE, internal last-index register=0, timer=0.
- States: IDLE, WAIT, DONE, FAIL.
- IDLE: outputs 0. If E=1, latch data into last-index register, SEQUSER=0, go WAIT next cycle. key_valid is ignored.
- WAIT (busy=1): on key_valid=1, compare key_code with exp_code in the same cycle. Registered result appears on the next edge (1-cycle latency).
  - Mismatch: go FAIL, err_User=1, SEQUSER holds.
  - Match and SEQUSER==latched last index: go DONE, end_User=1, SEQUSER holds.
  - Match otherwise: SEQUSER+1, stay WAIT.
- DONE / FAIL: flags held, SEQUSER held, key_valid ignored. When E=0, next cycle go IDLE, flags cleared, SEQUSER=0.
- E dropped in WAIT: return to IDLE next cycle, SEQUSER=0, no flag raised. A simultaneous key_valid is discarded.
- Changes on data after entry to WAIT are ignored until the next IDLE->WAIT.
- data=0: a single correct key completes the round.
- SEQUSER never wraps: the max value is the latched last index ≤ 2^SIZE-1. Increment is SIZE-bit unsigned.
- end_User and err_User are never high together.
- Consecutive key_valid on back-to-back cycles are each processed. exp_code must track the new SEQUSER within the same cycle.
- R mid-round: next cycle everything is at reset values regardless of E. If E is still 1, the block re-enters WAIT one cycle later.

Optional Feature:
- Macro USER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on every key_valid and on entry to WAIT.
  - Reaching TIMEOUT_CYCLES-1 without a press moves the block to FAIL with err_User=1, same as a wrong key.
  - A key_valid arriving in the same cycle as expiry wins: it is evaluated normally.
- Not defined: no timer logic; WAIT waits indefinitely.

Test Plan:
- R=1 2 cycles, E=0 -> all outputs 0; then E=1, data=3 -> busy=1 after 1 cycle, SEQUSER=0.
- data=3, exp sequence 2,0,3,1, keys 2,0,3,1 one per 3 cycles -> SEQUSER 0→1→2→3, end_User=1 one cycle after 4th press, err_User=0; E=0 -> next cycle end_User=0, SEQUSER=0.
- data=3, keys 2,1 (expected 2,0) -> err_User=1 one cycle after 2nd press, SEQUSER=1 held, further presses ignored.
- data=0, key matching exp_code -> end_User=1 after 1 cycle; back-to-back presses on data=2 with correct codes -> end_User after third consecutive strobe.
- E dropped at SEQUSER=2 with simultaneous key_valid -> IDLE, SEQUSER=0, both flags 0; R asserted in DONE -> flags 0 next cycle.
- USER_TIMEOUT_EN, TIMEOUT_CYCLES=8, E=1 no presses -> err_User=1 after 8 cycles in WAIT; press at cycle 5 restarts the count.
